dds_phase_accum_a8: RTL and testbench

//  DDS phase accumulator and address generator that drives the 8-bit-address waveform ROMs (sine/triangular/square, a8d8).

---
 rtl/dds_phase_accum_a8_if.sv | 29 ++
 rtl/dds_phase_accum_a8.sv | 167 ++++++++++++++++
 tb/tb_dds_phase_accum_a8.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_phase_accum_a8_if.sv
// Control/status bundle for the DDS phase accumulator.
// master = controller side (drives requests and configuration); slave = accumulator side.
interface dds_phase_accum_a8_if #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  start;
    logic                  stop;
    logic                  cfg_load;
    logic [ACC_WIDTH-1:0]  fcw_in;
    logic [ADDR_WIDTH-1:0] phase_in;
    logic [CNT_WIDTH-1:0]  burst_len;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_valid;
    logic                  cycle_sync;
    logic                  busy;
    logic                  cfg_pending;

    modport master (
        output start, stop, cfg_load, fcw_in, phase_in, burst_len,
        input  addr, addr_valid, cycle_sync, busy, cfg_pending
    );

    modport slave (
        input  start, stop, cfg_load, fcw_in, phase_in, burst_len,
        output addr, addr_valid, cycle_sync, busy, cfg_pending
    );
endinterface

// File: rtl/dds_phase_accum_a8.sv
// DDS phase accumulator / ROM address generator.
// Adds the active FCW to the accumulator every cycle and emits the top
// ADDR_WIDTH bits plus a phase offset as the ROM address. Supports continuous
// or N-period bursts, clean stop at a period boundary and retune at the wrap.
module dds_phase_accum_a8 #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    dds_phase_accum_a8_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPING
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  fcw_act_q, fcw_act_d;
    logic [ACC_WIDTH-1:0]  fcw_sh_q, fcw_sh_d;
    logic [ADDR_WIDTH-1:0] ph_act_q, ph_act_d;
    logic [ADDR_WIDTH-1:0] ph_sh_q, ph_sh_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  cycle_sync_q, cycle_sync_d;
    logic                  cfg_pending_q, cfg_pending_d;

    logic [ACC_WIDTH:0]    sum;
    logic                  wrap;
    logic                  end_run;

    // State register and all datapath flops; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            fcw_act_q     <= '0;
            fcw_sh_q      <= '0;
            ph_act_q      <= '0;
            ph_sh_q       <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            addr_valid_q  <= 1'b0;
            cycle_sync_q  <= 1'b0;
            cfg_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            fcw_act_q     <= fcw_act_d;
            fcw_sh_q      <= fcw_sh_d;
            ph_act_q      <= ph_act_d;
            ph_sh_q       <= ph_sh_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            addr_valid_q  <= addr_valid_d;
            cycle_sync_q  <= cycle_sync_d;
            cfg_pending_q <= cfg_pending_d;
        end
    end

    // Next-state, accumulator step, retune and burst/stop termination.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        fcw_act_d     = fcw_act_q;
        fcw_sh_d      = fcw_sh_q;
        ph_act_d      = ph_act_q;
        ph_sh_d       = ph_sh_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        addr_valid_d  = addr_valid_q;
        cycle_sync_d  = 1'b0;
        cfg_pending_d = cfg_pending_q;
        end_run       = 1'b0;

        sum  = {1'b0, acc_q} + {1'b0, fcw_act_q};
        wrap = sum[ACC_WIDTH];

        case (state_q)
            S_IDLE: begin
                // Idle has no period boundary to wait for: a pending shadow goes live one cycle after capture.
                if (cfg_pending_q) begin
                    fcw_act_d     = fcw_sh_q;
                    ph_act_d      = ph_sh_q;
                    cfg_pending_d = 1'b0;
                end
                if (bus.cfg_load) begin
                    fcw_sh_d      = bus.fcw_in;
                    ph_sh_d       = bus.phase_in;
                    cfg_pending_d = 1'b1;
                end
                // Launch uses the currently active phase; stop is ignored here.
                if (bus.start) begin
                    state_d      = S_RUN;
                    acc_d        = '0;
                    cnt_d        = bus.burst_len;
                    addr_d       = ph_act_q;
                    addr_valid_d = 1'b1;
                end
            end

            S_RUN, S_STOPPING: begin
                acc_d        = sum[ACC_WIDTH-1:0];
                addr_d       = sum[ACC_WIDTH-1 -: ADDR_WIDTH] + ph_act_q;
                addr_valid_d = 1'b1;
                cycle_sync_d = wrap;

                if (wrap) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                    if (cnt_q == CNT_WIDTH'(1) || state_q == S_STOPPING) begin
                        end_run = 1'b1;
                    end
                end

                // Burst end outranks stop; a stop with zero FCW would never reach a wrap, so end now.
                if (state_q == S_RUN && bus.stop && !end_run) begin
                    if (fcw_act_q == '0) begin
                        end_run = 1'b1;
                    end else begin
                        state_d = S_STOPPING;
                    end
                end

                // Retune only at the wrap; a load coinciding with the wrap bypasses the shadow.
                if (bus.cfg_load && wrap) begin
                    fcw_act_d     = bus.fcw_in;
                    ph_act_d      = bus.phase_in;
                    cfg_pending_d = 1'b0;
                end else if (bus.cfg_load) begin
                    fcw_sh_d      = bus.fcw_in;
                    ph_sh_d       = bus.phase_in;
                    cfg_pending_d = 1'b1;
                end else if (wrap && cfg_pending_q) begin
                    fcw_act_d     = fcw_sh_q;
                    ph_act_d      = ph_sh_q;
                    cfg_pending_d = 1'b0;
                end

                if (end_run) begin
                    state_d      = S_IDLE;
                    acc_d        = '0;
                    addr_d       = addr_q;
                    addr_valid_d = 1'b0;
                    cycle_sync_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.addr        = addr_q;
    assign bus.addr_valid  = addr_valid_q;
    assign bus.cycle_sync  = cycle_sync_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_dds_phase_accum_a8.sv
// Testbench for dds_phase_accum_a8: directed scenarios with literal expectations,
// plus a cycle-level behavioural model compared against the outputs every cycle.
module tb_dds_phase_accum_a8;

    localparam longint unsigned TWO32 = 64'h1_0000_0000;
    localparam longint unsigned F24   = 64'h0100_0000;
    localparam longint unsigned F25   = 64'h0200_0000;
    localparam longint unsigned F30   = 64'h4000_0000;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    dds_phase_accum_a8_if #(.ACC_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) bus ();

    dds_phase_accum_a8 #(.ACC_WIDTH(32), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 idle, 1 running, 2 finishing the current period.
    int               m_mode;
    longint unsigned  m_phase, m_fcw, m_sfcw;
    int               m_ofs, m_sofs, m_addr, m_left;
    bit               m_pend, m_valid, m_sync;

    always @(posedge clk) begin
        longint unsigned nxt;
        bit              crossed;
        bit              done;
        int              launch_addr;
        if (rst) begin
            m_mode = 0; m_phase = 0; m_fcw = 0; m_sfcw = 0;
            m_ofs = 0; m_sofs = 0; m_addr = 0; m_left = 0;
            m_pend = 0; m_valid = 0; m_sync = 0;
        end else begin
            nxt     = m_phase + m_fcw;
            crossed = (nxt >= TWO32);
            nxt     = nxt % TWO32;
            m_sync  = 0;
            if (m_mode == 0) begin
                launch_addr = m_ofs;
                if (m_pend) begin
                    m_fcw = m_sfcw; m_ofs = m_sofs; m_pend = 0;
                end
                if (bus.cfg_load) begin
                    m_sfcw = bus.fcw_in; m_sofs = int'(bus.phase_in); m_pend = 1;
                end
                if (bus.start) begin
                    m_mode = 1; m_phase = 0; m_left = int'(bus.burst_len);
                    m_addr = launch_addr; m_valid = 1;
                end
            end else begin
                done = 0;
                if (crossed) begin
                    if (m_left == 1 || m_mode == 2) done = 1;
                    if (m_left > 0) m_left = m_left - 1;
                end
                if (!done && m_mode == 1 && bus.stop) begin
                    if (m_fcw == 0) done = 1;
                    else m_mode = 2;
                end
                begin
                    int new_addr;
                    new_addr = int'(((nxt >> 24) + longint'(m_ofs)) % 256);
                    if (bus.cfg_load && crossed) begin
                        m_fcw = bus.fcw_in; m_ofs = int'(bus.phase_in); m_pend = 0;
                    end else if (bus.cfg_load) begin
                        m_sfcw = bus.fcw_in; m_sofs = int'(bus.phase_in); m_pend = 1;
                    end else if (crossed && m_pend) begin
                        m_fcw = m_sfcw; m_ofs = m_sofs; m_pend = 0;
                    end
                    if (done) begin
                        m_mode = 0; m_valid = 0; m_phase = 0;
                    end else begin
                        m_phase = nxt; m_addr = new_addr; m_sync = crossed;
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_addr",        longint'(bus.addr),        longint'(m_addr));
        check("model_addr_valid",  longint'(bus.addr_valid),  longint'(m_valid));
        check("model_cycle_sync",  longint'(bus.cycle_sync),  longint'(m_sync));
        check("model_busy",        longint'(bus.busy),        longint'(m_mode != 0));
        check("model_cfg_pending", longint'(bus.cfg_pending), longint'(m_pend));
    end

    // ---------------- stimulus helpers (called just after a negedge) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_cfg(input longint unsigned f, input int p);
        bus.fcw_in   = f[31:0];
        bus.phase_in = p[7:0];
        bus.cfg_load = 1'b1;
        tick();
        bus.cfg_load = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_addr(input string name, input int a, input int bound);
        int found = 0;
        for (int i = 0; i < bound; i++) begin
            if (int'(bus.addr) == a) begin
                found = 1;
                break;
            end
            tick();
        end
        check(name, found, 1);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int found = 0;
        for (int i = 0; i < bound; i++) begin
            if (!bus.busy) begin
                found = 1;
                break;
            end
            tick();
        end
        check(name, found, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int last;
        int e;
        int nsync;
        int seen;
        int q[$];
        int exp3[8];

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_load  = 1'b0;
        bus.fcw_in    = '0;
        bus.phase_in  = '0;
        bus.burst_len = '0;
        repeat (3) tick();
        check("rst_addr",        bus.addr,        0);
        check("rst_addr_valid",  bus.addr_valid,  0);
        check("rst_cycle_sync",  bus.cycle_sync,  0);
        check("rst_busy",        bus.busy,        0);
        check("rst_cfg_pending", bus.cfg_pending, 0);
        rst = 1'b0;
        tick();

        // Continuous ramp at step 1
        load_cfg(F24, 0);
        check("idle_pending_set", bus.cfg_pending, 1);
        tick();
        check("idle_pending_clr", bus.cfg_pending, 0);
        bus.burst_len = 16'd0;
        pulse_start();
        check("t2_first_addr",  bus.addr,       0);
        check("t2_first_valid", bus.addr_valid, 1);
        check("t2_first_sync",  bus.cycle_sync, 0);
        for (int k = 1; k <= 600; k++) begin
            tick();
            check("t2_addr", bus.addr, k % 256);
            check("t2_sync", bus.cycle_sync, (k % 256 == 0) ? 1 : 0);
        end

        // Stop at 0x80 finishes the period at 0xFF
        wait_addr("t5_wait_80", 8'h80, 300);
        pulse_stop();
        check("t5_busy_after_stop", bus.busy, 1);
        last = -1;
        for (int i = 0; i < 300 && bus.addr_valid; i++) begin
            last = int'(bus.addr);
            tick();
        end
        check("t5_last_addr", last, 8'hFF);
        check("t5_addr_hold", bus.addr, 8'hFF);
        check("t5_valid",     bus.addr_valid, 0);
        check("t5_busy",      bus.busy, 0);

        // Zero FCW: stop ends the run on the next edge
        load_cfg(0, 0);
        tick();
        pulse_start();
        check("t5z_valid_run", bus.addr_valid, 1);
        repeat (3) tick();
        pulse_stop();
        check("t5z_busy",  bus.busy, 0);
        check("t5z_valid", bus.addr_valid, 0);

        // Reset mid-run
        load_cfg(F24, 0);
        tick();
        pulse_start();
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("t1_addr",        bus.addr,        0);
        check("t1_addr_valid",  bus.addr_valid,  0);
        check("t1_cycle_sync",  bus.cycle_sync,  0);
        check("t1_busy",        bus.busy,        0);
        check("t1_cfg_pending", bus.cfg_pending, 0);
        tick();
        rst = 1'b0;
        tick();

        // Two-period burst at step 64
        load_cfg(F30, 0);
        tick();
        bus.burst_len = 16'd2;
        pulse_start();
        nsync = 0;
        for (int i = 0; i < 40 && bus.addr_valid; i++) begin
            q.push_back(int'(bus.addr));
            nsync += int'(bus.cycle_sync);
            tick();
        end
        exp3 = '{0, 64, 128, 192, 0, 64, 128, 192};
        check("t3_count", q.size(), 8);
        for (int i = 0; i < 8 && i < q.size(); i++) check("t3_addr", q[i], exp3[i]);
        check("t3_syncs", nsync, 1);
        check("t3_busy",  bus.busy, 0);
        check("t3_valid", bus.addr_valid, 0);

        // Retune mid-period takes effect at the wrap
        load_cfg(F24, 0);
        tick();
        bus.burst_len = 16'd0;
        pulse_start();
        wait_addr("t4_wait_10", 8'h10, 300);
        load_cfg(F25, 0);
        e = 8'h11;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.cycle_sync) begin
                seen = 1;
                break;
            end
            check("t4_addr_step1", bus.addr, e);
            check("t4_pending",    bus.cfg_pending, 1);
            e++;
            tick();
        end
        check("t4_wrap_seen",  seen, 1);
        check("t4_wrap_addr",  bus.addr, 0);
        check("t4_pending_clr", bus.cfg_pending, 0);
        tick();
        check("t4_addr_02", bus.addr, 8'h02);
        tick();
        check("t4_addr_04", bus.addr, 8'h04);
        pulse_stop();
        wait_idle("t4_idle", 300);

        // Phase offset 0x40
        load_cfg(F24, 8'h40);
        tick();
        pulse_start();
        check("t6_first_addr", bus.addr, 8'h40);
        last = int'(bus.addr);
        seen = 0;
        nsync = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (last == 8'hFF) begin
                check("t6_ff_to_00", bus.addr, 0);
                check("t6_no_sync_at_00", bus.cycle_sync, 0);
                seen = 1;
            end
            if (bus.cycle_sync) begin
                nsync = 1;
                break;
            end
            last = int'(bus.addr);
        end
        check("t6_wrap_seen", seen, 1);
        check("t6_sync_seen", nsync, 1);
        check("t6_sync_addr", bus.addr, 8'h40);
        pulse_stop();
        wait_idle("t6_idle", 300);

        // start and stop together in idle: start wins
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("ss_busy",  bus.busy, 1);
        check("ss_valid", bus.addr_valid, 1);
        check("ss_addr",  bus.addr, 8'h40);
        tick();
        pulse_stop();
        wait_idle("ss_idle", 300);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
